// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arbiter
//  Description : Two-port arbiter in front of the single dm_4k data-memory
//                port. Port 0 (pipeline MEM stage) wins by default; port 1
//                (loader/debug) gets a forced slot after STARVE_LIM denied
//                cycles and may lock up to BURST_MAX consecutive beats.
//  Revision    : 1.0  initial release
// ============================================================================
module dm_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4,
    parameter int BURST_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // port 0: pipeline MEM stage
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [1:0]        we0,
    input  logic [1:0]        rd0,
    // port 1: loader / debug master
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [1:0]        we1,
    input  logic [1:0]        rd1,
    input  logic              lock1,
    // grant / stall
    output logic              gnt0,
    output logic              gnt1,
    output logic              stall0,
    output logic [DATA_W-1:0] rdata,
    // dm_4k side
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_din,
    output logic [1:0]        m_we,
    output logic [1:0]        m_rd,
    input  logic [DATA_W-1:0] m_dout
);

    localparam logic [3:0] c_starve_lim = 4'(STARVE_LIM);
    localparam logic [3:0] c_burst_max  = 4'(BURST_MAX);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t     r_state;
    logic [3:0] r_wait_cnt;
    logic [3:0] r_burst_cnt;

    logic       w_burst_hold;
    logic       w_starve;
    logic       w_sel0;
    logic       w_sel1;

    // Priority grant: locked burst, then starvation slot, then port 0, then port 1
    always_comb begin
        w_burst_hold = (r_state == ST_BURST) && req1 && (r_burst_cnt < c_burst_max);
        w_starve     = req1 && (r_wait_cnt == c_starve_lim);
        w_sel0       = 1'b0;
        w_sel1       = 1'b0;
        if (w_burst_hold || w_starve) begin
            w_sel1 = 1'b1;
        end else if (req0) begin
            w_sel0 = 1'b1;
        end else if (req1) begin
            w_sel1 = 1'b1;
        end
    end

    // Grant outputs and memory mux; everything is held quiet while in reset
    always_comb begin
        gnt0   = rst_n & w_sel0;
        gnt1   = rst_n & w_sel1;
        stall0 = rst_n & req0 & ~w_sel0;
        m_addr = '0;
        m_din  = '0;
        m_we   = 2'b00;
        m_rd   = 2'b00;
        if (gnt0) begin
            m_addr = addr0;
            m_din  = wdata0;
            m_we   = we0;
            m_rd   = rd0;
        end else if (gnt1) begin
            m_addr = addr1;
            m_din  = wdata1;
            m_we   = we1;
            m_rd   = rd1;
        end
    end

    // Read data is a straight passthrough; only the granted port samples it
    assign rdata = m_dout;

    // Count consecutive denied port-1 cycles, saturating at the starvation limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 4'd0;
        end else if (req1 && !w_sel1) begin
            if (r_wait_cnt < c_starve_lim) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end else begin
            r_wait_cnt <= 4'd0;
        end
    end

    // Burst tracker: a locked grant opens a burst, capped at BURST_MAX beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_burst_cnt <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel1 && lock1) begin
                        r_state     <= ST_BURST;
                        r_burst_cnt <= 4'd1;
                    end
                end
                ST_BURST: begin
                    if (w_sel1 && lock1 && (r_burst_cnt < c_burst_max)) begin
                        r_burst_cnt <= r_burst_cnt + 4'd1;
                    end else begin
                        // cap reached, lock dropped or port 1 went away
                        r_state     <= ST_IDLE;
                        r_burst_cnt <= 4'd0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_burst_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
